// File: rtl/knn_trainset_loader.sv
// knn_trainset_loader
//   Write side of the kNN training-set interface. Labelled points arrive over
//   a valid/ready stream into a staging bank. A commit copies the whole
//   staging bank into the active bank in a single cycle. The classifier only
//   reads the active bank, so it never sees a partially loaded set.
//
// Ports
//   clk_i, rst_i       clock, async active-high reset
//   s_valid_i/s_ready_o  sample handshake (ready never depends on valid)
//   s_point_i          {x[15:0], y[15:0]} packed point
//   s_class_i          sample label
//   clear_i            empty the staging bank (pulse)
//   commit_i           copy staging to active (pulse)
//   commit_done_o      pulse: active bank has just been updated
//   points_o/classes_o active bank contents, entry i at [W*i +: W]
//   valid_mask_o       active entries that hold a loaded sample
//   stage_count_o      occupied staging entries
//   label_err_o        sticky: an out-of-range label was offered
//
// FSM
//   state  | meaning
//   FILL   | accepting samples, clear and commit honoured
//   COMMIT | one cycle: active <= staging, stream stalled
module knn_trainset_loader #(
   parameter int NPoints   = 17,
   parameter int Classes   = 2,
   parameter bit Overwrite = 1'b0,
   localparam int IW   = $clog2(NPoints),
   localparam int CNTW = $clog2(NPoints + 1),
   localparam int CW   = (Classes > 1) ? $clog2(Classes) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [31:0]           s_point_i,
   input  logic [CW-1:0]         s_class_i,
   input  logic                  clear_i,
   input  logic                  commit_i,
   output logic                  commit_done_o,
   output logic [32*NPoints-1:0] points_o,
   output logic [CW*NPoints-1:0] classes_o,
   output logic [NPoints-1:0]    valid_mask_o,
   output logic [CNTW-1:0]       stage_count_o,
   output logic                  label_err_o
);

   localparam logic [0:0] ST_FILL   = 1'b0;
   localparam logic [0:0] ST_COMMIT = 1'b1;

   localparam int CWP = CW + 1;
   localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(NPoints);
   localparam logic [IW-1:0]   LAST_IDX  = IW'(NPoints - 1);
   localparam logic [CW:0]     CLASS_LIM = CWP'(Classes);

   logic [0:0]         state;
   logic [31:0]        stg_point [NPoints];
   logic [CW-1:0]      stg_class [NPoints];
   logic [NPoints-1:0] stg_mask;
   logic [CNTW-1:0]    stage_cnt;
   logic [IW-1:0]      wr_ptr;

   logic [31:0]        act_point [NPoints];
   logic [CW-1:0]      act_class [NPoints];
   logic [NPoints-1:0] act_mask;

   logic               commit_done;
   logic               label_err;

   logic in_fill;
   logic full;
   logic label_bad;
   logic accept;
   logic do_clear;
   logic do_commit;

   assign in_fill   = (state == ST_FILL);
   assign full      = (stage_cnt == FULL_CNT);
   // Only reachable when Classes is not a power of two; otherwise every
   // encodable label is in range and this folds to 0.
   assign label_bad = ({1'b0, s_class_i} >= CLASS_LIM);

   assign s_ready_o = in_fill & ~clear_i & ~commit_i & (~full | Overwrite);

   // An out-of-range label still completes the handshake but is discarded.
   assign accept    = s_valid_i & s_ready_o & ~label_bad;
   assign do_clear  = clear_i & in_fill;
   assign do_commit = commit_i & ~clear_i & in_fill;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_FILL;
      end else begin
         case (state)
            ST_FILL:   state <= do_commit ? ST_COMMIT : ST_FILL;
            ST_COMMIT: state <= ST_FILL;
            default:   state <= ST_FILL;
         endcase
      end
   end

   // Staging bank. When full with Overwrite set, wr_ptr already points at the
   // oldest entry, so a plain write at wr_ptr gives ring behaviour.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NPoints; i++) begin
            stg_point[i] <= '0;
            stg_class[i] <= '0;
         end
         stg_mask  <= '0;
         stage_cnt <= '0;
         wr_ptr    <= '0;
      end else if (do_clear) begin
         stg_mask  <= '0;
         stage_cnt <= '0;
         wr_ptr    <= '0;
      end else if (accept) begin
         stg_point[wr_ptr] <= s_point_i;
         stg_class[wr_ptr] <= s_class_i;
         stg_mask[wr_ptr]  <= 1'b1;
         wr_ptr            <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
         if (!full) begin
            stage_cnt <= stage_cnt + 1'b1;
         end
      end
   end

   // Active bank. Staging is frozen during COMMIT (ready is low, clear is
   // ignored), so the copy is a consistent snapshot.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NPoints; i++) begin
            act_point[i] <= '0;
            act_class[i] <= '0;
         end
         act_mask <= '0;
      end else if (state == ST_COMMIT) begin
         for (int i = 0; i < NPoints; i++) begin
            act_point[i] <= stg_point[i];
            act_class[i] <= stg_class[i];
         end
         act_mask <= stg_mask;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         commit_done <= 1'b0;
         label_err   <= 1'b0;
      end else begin
         commit_done <= (state == ST_COMMIT);
         if (do_clear) begin
            label_err <= 1'b0;
         end else if (s_valid_i & label_bad) begin
            label_err <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NPoints; g++) begin : g_out
      assign points_o[32*g +: 32]  = act_point[g];
      assign classes_o[CW*g +: CW] = act_class[g];
   end

   assign valid_mask_o  = act_mask;
   assign stage_count_o = stage_cnt;
   assign commit_done_o = commit_done;
   assign label_err_o   = label_err;

endmodule

// File: tb/tb_knn_trainset_loader.sv
module tb_knn_trainset_loader;

   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   // main instance: Classes=3, Overwrite=0
   logic          s_valid, s_ready, clear, commit, commit_done, label_err;
   logic [31:0]   s_point;
   logic [1:0]    s_class;
   logic [543:0]  points;
   logic [33:0]   classes;
   logic [16:0]   mask;
   logic [4:0]    count;

   // ring instance: Classes=2, Overwrite=1
   logic          o_valid, o_ready, o_clear, o_commit, o_done, o_lerr;
   logic [31:0]   o_point;
   logic [0:0]    o_class;
   logic [543:0]  o_points;
   logic [16:0]   o_classes;
   logic [16:0]   o_mask;
   logic [4:0]    o_count;

   knn_trainset_loader #(.NPoints(17), .Classes(3), .Overwrite(1'b0)) u_dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_valid_i(s_valid), .s_ready_o(s_ready), .s_point_i(s_point), .s_class_i(s_class),
      .clear_i(clear), .commit_i(commit), .commit_done_o(commit_done),
      .points_o(points), .classes_o(classes), .valid_mask_o(mask),
      .stage_count_o(count), .label_err_o(label_err));

   knn_trainset_loader #(.NPoints(17), .Classes(2), .Overwrite(1'b1)) u_ow (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_valid_i(o_valid), .s_ready_o(o_ready), .s_point_i(o_point), .s_class_i(o_class),
      .clear_i(o_clear), .commit_i(o_commit), .commit_done_o(o_done),
      .points_o(o_points), .classes_o(o_classes), .valid_mask_o(o_mask),
      .stage_count_o(o_count), .label_err_o(o_lerr));

   int vecs = 0;
   int errs = 0;

   typedef struct {
      logic [543:0] pts;
      logic [33:0]  cls;
      logic [16:0]  mask;
   } exp_t;

   exp_t sb[$];
   logic [31:0] exp_pt [17];
   logic [1:0]  exp_cl [17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every commit_done pulse must match the oldest pending expectation.
   always @(negedge clk_i) begin
      if (!rst_i && commit_done) begin
         if (sb.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL commit_unexpected: got commit_done=1 expected no commit");
         end else begin : pop_blk
            exp_t e;
            e = sb.pop_front();
            chk("commit_mask", 32'(mask), 32'(e.mask));
            for (int i = 0; i < 17; i++) begin
               if (e.mask[i]) begin
                  chk($sformatf("commit_point[%0d]", i), points[32*i +: 32], e.pts[32*i +: 32]);
                  chk($sformatf("commit_class[%0d]", i), 32'(classes[2*i +: 2]), 32'(e.cls[2*i +: 2]));
               end
            end
         end
      end
   end

   task automatic push_exp(input logic [16:0] m);
      exp_t e;
      for (int i = 0; i < 17; i++) begin
         e.pts[32*i +: 32] = exp_pt[i];
         e.cls[2*i +: 2]   = exp_cl[i];
      end
      e.mask = m;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send(input int idx, input logic [31:0] p, input logic [1:0] c);
      int n;
      n = 0;
      s_valid = 1'b1; s_point = p; s_class = c;
      @(negedge clk_i);
      while (!s_ready && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (!s_ready) chk("send_timeout", 32'(s_ready), 32'd1);
      tick();
      s_valid = 1'b0;
      exp_pt[idx] = p;
      exp_cl[idx] = c;
   endtask

   task automatic o_send(input logic [31:0] p, input logic c);
      int n;
      n = 0;
      o_valid = 1'b1; o_point = p; o_class = c;
      @(negedge clk_i);
      while (!o_ready && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (!o_ready) chk("o_send_timeout", 32'(o_ready), 32'd1);
      tick();
      o_valid = 1'b0;
   endtask

   // commit pulse with cycle-accurate check of done latency
   task automatic do_commit(input logic [16:0] m);
      push_exp(m);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      @(negedge clk_i);
      chk("commit_t1_done", 32'(commit_done), 32'd0);
      chk("commit_t1_ready", 32'(s_ready), 32'd0);
      tick();
      @(negedge clk_i);
      chk("commit_t2_done", 32'(commit_done), 32'd1);
      tick();
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_i = 1'b1;
      s_valid = 0; s_point = 0; s_class = 0; clear = 0; commit = 0;
      o_valid = 0; o_point = 0; o_class = 0; o_clear = 0; o_commit = 0;
      for (int i = 0; i < 17; i++) begin exp_pt[i] = 0; exp_cl[i] = 0; end
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_ready", 32'(s_ready), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_mask", 32'(mask), 32'd0);
      tick();

      // load 3 and commit
      send(0, 32'h0001_0002, 2'd1);
      send(1, 32'h0010_0010, 2'd0);
      send(2, 32'hFFFF_0000, 2'd1);
      do_commit(17'h00007);
      @(negedge clk_i);
      chk("load3_count", 32'(count), 32'd3);
      chk("load3_mask", 32'(mask), 32'h7);
      tick();

      // clear + commit + valid together: clear wins, nothing else happens
      clear = 1'b1; commit = 1'b1; s_valid = 1'b1; s_point = 32'hDEAD_BEEF; s_class = 2'd2;
      @(negedge clk_i);
      chk("ccv_ready", 32'(s_ready), 32'd0);
      tick();
      clear = 1'b0; commit = 1'b0; s_valid = 1'b0;
      @(negedge clk_i);
      chk("ccv_count", 32'(count), 32'd0);
      chk("ccv_done1", 32'(commit_done), 32'd0);
      tick();
      @(negedge clk_i);
      chk("ccv_done2", 32'(commit_done), 32'd0);
      chk("ccv_mask_kept", 32'(mask), 32'h7);
      chk("ccv_point0_kept", points[31:0], 32'h0001_0002);
      chk("ccv_point2_kept", points[95:64], 32'hFFFF_0000);
      tick();

      // reset mid-stream
      send(0, 32'h1234_5678, 2'd2);
      s_valid = 1'b1; s_point = 32'h5555_AAAA; s_class = 2'd0;
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      chk("midrst_mask", 32'(mask), 32'd0);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_point0", points[31:0], 32'd0);
      chk("midrst_point2", points[95:64], 32'd0);
      chk("midrst_class0", 32'(classes[1:0]), 32'd0);
      chk("midrst_done", 32'(commit_done), 32'd0);
      chk("midrst_lerr", 32'(label_err), 32'd0);
      tick();
      rst_i = 1'b0;
      s_valid = 1'b0;
      @(negedge clk_i);
      chk("midrst_ready_after", 32'(s_ready), 32'd1);
      chk("midrst_count_after", 32'(count), 32'd0);
      tick();

      // out-of-range label
      send(0, 32'h0000_0001, 2'd2);
      s_valid = 1'b1; s_point = 32'h0000_0002; s_class = 2'd3;
      @(negedge clk_i);
      chk("badlbl_ready", 32'(s_ready), 32'd1);
      tick();
      s_valid = 1'b0;
      @(negedge clk_i);
      chk("badlbl_err", 32'(label_err), 32'd1);
      chk("badlbl_count", 32'(count), 32'd1);
      tick();
      pulse_clear();
      @(negedge clk_i);
      chk("badlbl_err_cleared", 32'(label_err), 32'd0);
      chk("clear_count", 32'(count), 32'd0);
      tick();

      // incremental commits
      for (int i = 0; i < 5; i++) send(i, 32'hA5A5_0000 + 32'(i), 2'(i % 3));
      do_commit(17'h0001F);
      send(5, 32'hA5A5_0005, 2'd2);
      send(6, 32'hA5A5_0006, 2'd0);
      @(negedge clk_i);
      chk("incr_count", 32'(count), 32'd7);
      chk("incr_mask_kept", 32'(mask), 32'h1F);
      chk("incr_point4_kept", points[159:128], 32'hA5A5_0004);
      tick();
      do_commit(17'h0007F);

      // backpressure when full
      pulse_clear();
      for (int i = 0; i < 17; i++) send(i, 32'hC000_0000 + 32'(i), 2'(i % 3));
      @(negedge clk_i);
      chk("full_count", 32'(count), 32'd17);
      tick();
      s_valid = 1'b1; s_point = 32'hDEAD_BEEF; s_class = 2'd1;
      @(negedge clk_i);
      chk("full_ready", 32'(s_ready), 32'd0);
      tick();
      @(negedge clk_i);
      chk("full_ready_held", 32'(s_ready), 32'd0);
      chk("full_count_held", 32'(count), 32'd17);
      tick();
      s_valid = 1'b0;
      do_commit(17'h1FFFF);

      // ring overwrite instance
      for (int i = 0; i < 18; i++) o_send(32'hB000_0000 + 32'(i), 1'(i % 2));
      @(negedge clk_i);
      chk("ring_count", 32'(o_count), 32'd17);
      chk("ring_ready", 32'(o_ready), 32'd1);
      tick();
      o_commit = 1'b1;
      tick();
      o_commit = 1'b0;
      tick();
      @(negedge clk_i);
      chk("ring_done", 32'(o_done), 32'd1);
      chk("ring_point0", o_points[31:0], 32'hB000_0011);
      chk("ring_class0", 32'(o_classes[0]), 32'd1);
      chk("ring_point1", o_points[63:32], 32'hB000_0001);
      chk("ring_point16", o_points[543:512], 32'hB000_0010);
      chk("ring_mask", 32'(o_mask), 32'h1FFFF);
      tick();

      tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
